// File: rtl/note_sequencer.sv
// Step sequencer that plays a pattern of notes/rests to a synth voice.
// Each step lasts T clk cycles; trig is held for the first G cycles.
module note_sequencer #(
    parameter int STEPS  = 8,
    parameter int TICK_W = 16,
    localparam int AW    = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [12:0]       wr_data,
    input  logic [TICK_W-1:0] tempo,
    input  logic [TICK_W-1:0] gate_len,
    input  logic [AW-1:0]     last_step,
    output logic              trig,
    output logic [11:0]       osc_count,
    output logic [AW-1:0]     step,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        REST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [AW-1:0]       step_q, step_d;
    logic                trig_d;
    logic [11:0]         osc_d;
    logic                busy_d;
    logic [12:0]         pattern [STEPS];

    logic [TICK_W-1:0]   t_eff;
    logic [TICK_W-1:0]   t_m1;
    logic [TICK_W-1:0]   g_eff;
    logic                at_boundary;
    logic                at_gate_end;
    logic [AW-1:0]       step_nxt;
    logic                load;
    logic [AW-1:0]       load_idx;
    logic [12:0]         slot_sel;

    // Effective step length and gate length, sampled live every cycle.
    always_comb begin
        t_eff       = (tempo == '0) ? TICK_W'(1) : tempo;
        t_m1        = t_eff - TICK_W'(1);
        g_eff       = (gate_len < t_m1) ? gate_len : t_m1;
        at_boundary = (tick_q == t_m1);
        at_gate_end = (tick_q == g_eff - TICK_W'(1));
        step_nxt    = (step_q >= last_step) ? '0 : step_q + AW'(1);
    end

    // Pattern storage; writes land in any state, reset turns every slot into a rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                pattern[i] <= '0;
            end
        end else if (wr_en) begin
            pattern[wr_addr] <= wr_data;
        end
    end

    // State register plus the registered outputs that travel with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            step_q    <= '0;
            trig      <= 1'b0;
            osc_count <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
            trig      <= trig_d;
            osc_count <= osc_d;
            busy      <= busy_d;
        end
    end

    // Next-state logic; the step boundary wins over the gate ending.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        step_d   = step_q;
        load     = 1'b0;
        load_idx = step_q;
        unique case (state_q)
            IDLE: begin
                tick_d = '0;
                step_d = '0;
                if (en) begin
                    load     = 1'b1;
                    load_idx = '0;
                end
            end
            default: begin
                if (!en) begin
                    state_d = IDLE;
                    tick_d  = '0;
                    step_d  = '0;
                end else if (at_boundary) begin
                    load     = 1'b1;
                    load_idx = step_nxt;
                    step_d   = step_nxt;
                    tick_d   = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                    if (state_q == GATE && at_gate_end) begin
                        state_d = REST;
                    end
                end
            end
        endcase
        // Slot is read from the current register contents, before any same-cycle write.
        slot_sel = pattern[load_idx];
        if (load) begin
            state_d = (slot_sel[12] && g_eff != '0) ? GATE : REST;
        end
    end

    // Output logic: next values of the registered trig/osc_count/busy.
    always_comb begin
        trig_d = (state_d == GATE);
        busy_d = (state_d != IDLE);
        osc_d  = osc_count;
        if (load && state_d == GATE) begin
            osc_d = slot_sel[11:0];
        end
    end

    assign step = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed testbench for note_sequencer.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_note_sequencer;

    localparam int STEPS  = 8;
    localparam int TICK_W = 16;
    localparam int AW     = 3;

    logic              clk;
    logic              rst;
    logic              en;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [12:0]       wr_data;
    logic [TICK_W-1:0] tempo;
    logic [TICK_W-1:0] gate_len;
    logic [AW-1:0]     last_step;
    logic              trig;
    logic [11:0]       osc_count;
    logic [AW-1:0]     step;
    logic              busy;

    int checks = 0;
    int errors = 0;

    note_sequencer #(.STEPS(STEPS), .TICK_W(TICK_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .tempo     (tempo),
        .gate_len  (gate_len),
        .last_step (last_step),
        .trig      (trig),
        .osc_count (osc_count),
        .step      (step),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input logic [AW-1:0] a, input logic [12:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        clk_cycle();
        wr_en   = 1'b0;
    endtask

    task automatic stop_run();
        en = 1'b0;
        clk_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_cycle();
        clk_cycle();
        checks++;
        if (trig !== 1'b0) begin
            errors++;
            $display("FAIL reset_trig got %0b want 0", trig);
        end
        checks++;
        if (osc_count !== 12'h000) begin
            errors++;
            $display("FAIL reset_osc got %h want 000", osc_count);
        end
        checks++;
        if (step !== 3'd0) begin
            errors++;
            $display("FAIL reset_step got %0d want 0", step);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %0b want 0", busy);
        end
        rst = 1'b0;
        clk_cycle();
    endtask

    task automatic test_basic();
        logic       e_trig;
        logic [2:0] e_step;
        logic [11:0] e_osc;
        write_slot(3'd0, 13'h1100);
        write_slot(3'd1, 13'h1200);
        last_step = 3'd1;
        tempo     = 16'd10;
        gate_len  = 16'd4;
        en        = 1'b1;
        clk_cycle();
        for (int c = 0; c < 40; c++) begin
            e_step = 3'((c % 20) / 10);
            e_trig = (c % 10) < 4;
            e_osc  = (e_step == 0) ? 12'h100 : 12'h200;
            checks++;
            if (trig !== e_trig) begin
                errors++;
                $display("FAIL basic_trig c=%0d got %0b want %0b", c, trig, e_trig);
            end
            checks++;
            if (step !== e_step) begin
                errors++;
                $display("FAIL basic_step c=%0d got %0d want %0d", c, step, e_step);
            end
            checks++;
            if (osc_count !== e_osc) begin
                errors++;
                $display("FAIL basic_osc c=%0d got %h want %h", c, osc_count, e_osc);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_busy c=%0d got %0b want 1", c, busy);
            end
            clk_cycle();
        end
        stop_run();
    endtask

    task automatic test_rest_slot();
        logic       e_trig;
        logic [2:0] e_step;
        write_slot(3'd1, 13'h00FF);
        en = 1'b1;
        clk_cycle();
        for (int c = 0; c < 40; c++) begin
            e_step = 3'((c % 20) / 10);
            e_trig = (e_step == 0) && ((c % 10) < 4);
            checks++;
            if (trig !== e_trig) begin
                errors++;
                $display("FAIL rest_trig c=%0d got %0b want %0b", c, trig, e_trig);
            end
            checks++;
            if (step !== e_step) begin
                errors++;
                $display("FAIL rest_step c=%0d got %0d want %0d", c, step, e_step);
            end
            checks++;
            if (osc_count !== 12'h100) begin
                errors++;
                $display("FAIL rest_osc c=%0d got %h want 100", c, osc_count);
            end
            clk_cycle();
        end
        stop_run();
    endtask

    task automatic test_tempo_one();
        logic [2:0] e_step;
        tempo    = 16'd0;
        gate_len = 16'd5;
        en       = 1'b1;
        clk_cycle();
        for (int c = 0; c < 10; c++) begin
            e_step = 3'(c % 2);
            checks++;
            if (trig !== 1'b0) begin
                errors++;
                $display("FAIL t1_trig c=%0d got %0b want 0", c, trig);
            end
            checks++;
            if (step !== e_step) begin
                errors++;
                $display("FAIL t1_step c=%0d got %0d want %0d", c, step, e_step);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL t1_busy c=%0d got %0b want 1", c, busy);
            end
            clk_cycle();
        end
        stop_run();
    endtask

    task automatic test_long_gate();
        logic       e_trig;
        logic [2:0] e_step;
        logic [11:0] e_osc;
        write_slot(3'd1, 13'h1200);
        tempo    = 16'd10;
        gate_len = 16'd20;
        en       = 1'b1;
        clk_cycle();
        for (int c = 0; c < 20; c++) begin
            e_step = 3'(c / 10);
            e_trig = (c % 10) < 9;
            e_osc  = (e_step == 0) ? 12'h100 : 12'h200;
            checks++;
            if (trig !== e_trig) begin
                errors++;
                $display("FAIL long_trig c=%0d got %0b want %0b", c, trig, e_trig);
            end
            checks++;
            if (step !== e_step) begin
                errors++;
                $display("FAIL long_step c=%0d got %0d want %0d", c, step, e_step);
            end
            checks++;
            if (osc_count !== e_osc) begin
                errors++;
                $display("FAIL long_osc c=%0d got %h want %h", c, osc_count, e_osc);
            end
            clk_cycle();
        end
        stop_run();
    endtask

    task automatic test_stop_restart();
        gate_len = 16'd4;
        en       = 1'b1;
        clk_cycle();
        repeat (12) clk_cycle();
        checks++;
        if (step !== 3'd1) begin
            errors++;
            $display("FAIL stop_pre_step got %0d want 1", step);
        end
        en = 1'b0;
        clk_cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_busy got %0b want 0", busy);
        end
        checks++;
        if (trig !== 1'b0) begin
            errors++;
            $display("FAIL stop_trig got %0b want 0", trig);
        end
        checks++;
        if (step !== 3'd0) begin
            errors++;
            $display("FAIL stop_step got %0d want 0", step);
        end
        checks++;
        if (osc_count !== 12'h200) begin
            errors++;
            $display("FAIL stop_osc got %h want 200", osc_count);
        end
        en = 1'b1;
        clk_cycle();
        checks++;
        if (trig !== 1'b1) begin
            errors++;
            $display("FAIL restart_trig got %0b want 1", trig);
        end
        checks++;
        if (osc_count !== 12'h100) begin
            errors++;
            $display("FAIL restart_osc got %h want 100", osc_count);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_busy got %0b want 1", busy);
        end
        stop_run();
    endtask

    task automatic test_rbw_and_reset();
        logic [2:0] e_step;
        en      = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 13'h1300;
        clk_cycle();
        wr_en = 1'b0;
        checks++;
        if (osc_count !== 12'h100) begin
            errors++;
            $display("FAIL rbw_first_osc got %h want 100", osc_count);
        end
        repeat (20) clk_cycle();
        checks++;
        if (osc_count !== 12'h300) begin
            errors++;
            $display("FAIL rbw_second_osc got %h want 300", osc_count);
        end
        checks++;
        if (trig !== 1'b1 || step !== 3'd0) begin
            errors++;
            $display("FAIL rbw_second_pos got trig=%0b step=%0d want 1/0", trig, step);
        end
        clk_cycle();
        rst = 1'b1;
        clk_cycle();
        rst = 1'b0;
        checks++;
        if ({trig, osc_count, step, busy} !== 17'd0) begin
            errors++;
            $display("FAIL midrst got trig=%0b osc=%h step=%0d busy=%0b want 0",
                     trig, osc_count, step, busy);
        end
        clk_cycle();
        for (int c = 0; c < 20; c++) begin
            e_step = 3'(c / 10);
            checks++;
            if (trig !== 1'b0 || osc_count !== 12'h000) begin
                errors++;
                $display("FAIL cleared c=%0d got trig=%0b osc=%h want 0/000",
                         c, trig, osc_count);
            end
            checks++;
            if (step !== e_step || busy !== 1'b1) begin
                errors++;
                $display("FAIL cleared_step c=%0d got %0d/%0b want %0d/1",
                         c, step, busy, e_step);
            end
            clk_cycle();
        end
        stop_run();
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        tempo     = 16'd10;
        gate_len  = 16'd4;
        last_step = 3'd1;
        test_reset();
        test_basic();
        test_rest_slot();
        test_tempo_one();
        test_long_gate();
        test_stop_restart();
        test_rbw_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 8, number of pattern slots (power of two).
REQ-002 SHALL have parameter TICK_W, default 16, width of tempo/gate tick counters.
REQ-003 SHALL have port clk  input  1  single clock, all state on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  run enable; 1 = play pattern, 0 = stop.
REQ-006 SHALL have port wr_en  input  1  pattern write strobe.
REQ-007 SHALL have port wr_addr  input  log2(STEPS)  pattern slot to write.
REQ-008 SHALL have port wr_data  input  13  bit12 = note valid (0 = rest), bits11:0 = oscillator count.
REQ-009 SHALL have port tempo  input  TICK_W  clk cycles per step.
REQ-010 SHALL have port gate_len  input  TICK_W  clk cycles trig is held high within a step.
REQ-011 SHALL have port last_step  input  log2(STEPS)  index of final step before wrap.
REQ-012 SHALL have port trig  output  1  note gate to the synth envelope, registered.
REQ-013 SHALL have port osc_count  output  12  oscillator period for the current note, registered.
REQ-014 SHALL have port step  output  log2(STEPS)  index of step currently playing.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL hold STEPS x 13-bit pattern registers; wr_en=1 writes wr_data to slot wr_addr on that edge, in any state.
REQ-017 SHALL implement states IDLE, GATE, REST; one tick counter tick (TICK_W bits).
REQ-018 SHALL use effective tempo T = max(tempo,1) and effective gate G = min(gate_len, T-1).
REQ-019 IDLE: trig=0, tick=0, step=0; when en=1, next cycle loads slot 0 (REQ-021) with tick=0.
REQ-020 Step load: if slot valid bit=1 and G>0 -> state GATE, trig=1, osc_count=slot[11:0]; otherwise -> state REST, trig=0, osc_count unchanged.
REQ-021 Step load SHALL read the slot value before any same-cycle write (read-before-write).
REQ-022 GATE/REST: tick increments by 1 each cycle while en=1.
REQ-023 GATE: when tick==G-1 -> REST, trig=0 next cycle.
REQ-024 Step boundary: when tick==T-1 -> tick=0, step = (step>=last_step) ? 0 : step+1, load that slot per REQ-020, all in the same next cycle.
REQ-025 If GATE exit and step boundary coincide, step boundary SHALL take priority.
REQ-026 T=1: every cycle is a boundary; G=0 so trig stays 0, step advances each cycle.
REQ-027 en=0 in GATE/REST -> IDLE next cycle: trig=0, step=0, tick=0, osc_count held.
REQ-028 tempo, gate_len, last_step SHALL be sampled live each cycle; last_step reduced below current step wraps to 0 at next boundary.
REQ-029 busy SHALL equal (state != IDLE), registered with state.
REQ-030 Latency: en rise at edge N -> trig/osc_count valid after edge N+1.

Reset
REQ-031 rst=1 at a posedge SHALL force state IDLE, trig=0, osc_count=0, step=0, tick=0, busy=0, all pattern slots=0 (rests).
REQ-032 rst SHALL take priority over wr_en and en in the same cycle; mid-run reset behaves identically.

Verification
REQ-033 Reset, write slot0=0x1_100, slot1=0x1_200, last_step=1, tempo=10, gate_len=4, en=1 -> trig high 4 cycles, low 6, osc_count 0x100 then 0x200, step 0,1,0,... period 20.
REQ-034 slot1=0x0_0FF (rest), same config -> step1 has trig=0 for 10 cycles, osc_count stays 0x100.
REQ-035 tempo=0, gate_len=5 -> T=1, trig never high, step toggles 0/1 each cycle.
REQ-036 gate_len=20, tempo=10 -> trig high 9 cycles, low 1 cycle per step.
REQ-037 en dropped at tick 2 of step1 -> next cycle IDLE, trig=0, step=0, busy=0; en reasserted restarts at slot0.
REQ-038 wr_en to slot0 with 0x1_300 on the cycle slot0 is loaded -> osc_count=0x100 this pass, 0x300 on next pass; rst asserted mid-GATE -> all outputs 0 next cycle, slots cleared.
